// File: rtl/cache_bus_pkg.sv
// Shared types for the cache bus arbiter: FSM state encodings, master indices
// and a helper that turns a master index into its per-master handshake bit.
package cache_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b11
  } state_t;

  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  function automatic logic [1:0] master_mask(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb2_pick.sv
// Combinational 2-way grant selection between the i-cache (bit 0) and the
// d-cache (bit 1). Optional feature macro: ARB_ROUND_ROBIN_EN (tie goes to the
// master that did not win last time); otherwise the d-cache wins every tie.
module arb2_pick
  import cache_bus_pkg::*;
(
  input  logic [1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       last_grant,
`endif
  output logic       grant
);

  // Pick the winning master index; only meaningful when some req bit is set
  always_comb begin
    grant = M_INST;
    if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = ~last_grant;
`else
      grant = M_DATA;
`endif
    end else if (req[M_DATA]) begin
      grant = M_DATA;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Two-master (i-cache / d-cache) arbiter onto a single sram-like bus port.
// At most one transaction is outstanding: IDLE arbitrates, ADDR presents the
// owner's request until mem_addr_ok, DATA waits for mem_data_ok.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie breaking).
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32  // only 32 is supported
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              m_req,
  input  logic [1:0]              m_wr,
  input  logic [3:0]              m_size,
  input  logic [2*ADDR_WIDTH-1:0] m_addr,
  input  logic [63:0]             m_wdata,
  output logic [31:0]             m_rdata,
  output logic [1:0]              m_addr_ok,
  output logic [1:0]              m_data_ok,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [1:0]              mem_size,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_addr_ok,
  input  logic                    mem_data_ok
);

  state_t state;
  logic   owner;
  logic   pick;

`ifdef ARB_ROUND_ROBIN_EN
  logic   last_grant;
`endif

  arb2_pick u_pick (
    .req        (m_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant),
`endif
    .grant      (pick)
  );

  // Transaction FSM: grant in IDLE, hold in ADDR until accepted, then DATA
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= M_INST;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= M_DATA;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|m_req) begin
            owner <= pick;
            state <= ADDR;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= pick;
`endif
          end
        end
        ADDR: begin
          if (mem_addr_ok) begin
            state <= mem_data_ok ? IDLE : DATA;
          end
        end
        DATA: begin
          if (mem_data_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus drive and handshake routing; everything is forced low while in reset
  // so an abandoned transaction cannot leak a handshake to a master.
  always_comb begin
    m_rdata   = '0;
    m_addr_ok = '0;
    m_data_ok = '0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      m_rdata = mem_rdata;
      case (state)
        ADDR: begin
          mem_req   = 1'b1;
          mem_wr    = m_wr[owner];
          mem_size  = owner ? m_size[3:2] : m_size[1:0];
          mem_addr  = owner ? m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                            : m_addr[ADDR_WIDTH-1:0];
          mem_wdata = owner ? m_wdata[63:32] : m_wdata[31:0];
          if (mem_addr_ok) begin
            m_addr_ok = master_mask(owner);
            if (mem_data_ok) begin
              m_data_ok = master_mask(owner);
            end
          end
        end
        DATA: begin
          if (mem_data_ok) begin
            m_data_ok = master_mask(owner);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req;
  logic [1:0]  m_wr;
  logic [3:0]  m_size;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [31:0] m_rdata;
  logic [1:0]  m_addr_ok;
  logic [1:0]  m_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  cache_bus_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req       (m_req),
    .m_wr        (m_wr),
    .m_size      (m_size),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .m_addr_ok   (m_addr_ok),
    .m_data_ok   (m_data_ok),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_bus();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  initial begin
    rst = 1'b1;
    m_req = '0; m_wr = '0; m_size = '0; m_addr = '0; m_wdata = '0;
    clear_bus();

    // Reset with both masters requesting: all outputs low
    tick();
    m_req = 2'b11;
    tick();
    sample();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_m_addr_ok", 64'(m_addr_ok), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_state", 64'(dut.state), 64'd0);
    m_req = '0;
    tick();
    rst = 1'b0;
    tick();

    // d-cache read of 0x1000: addr_ok at cycle 2, data_ok at cycle 4
    m_req = 2'b10; m_wr = 2'b00; m_size = 4'b1000; m_addr = 64'h0000_1000_0000_0000;
    mem_rdata = 32'h0BAD_F00D;
    sample();
    check("rd_c0_mem_req", 64'(mem_req), 64'd0);
    check("rd_idle_rdata", 64'(m_rdata), 64'h0BAD_F00D);
    tick();
    sample();
    check("rd_c1_mem_req", 64'(mem_req), 64'd1);
    check("rd_c1_mem_addr", 64'(mem_addr), 64'h1000);
    check("rd_c1_mem_wr", 64'(mem_wr), 64'd0);
    check("rd_c1_mem_size", 64'(mem_size), 64'd2);
    check("rd_c1_addr_ok", 64'(m_addr_ok), 64'd0);
    tick();
    mem_addr_ok = 1'b1;
    sample();
    check("rd_c2_addr_ok", 64'(m_addr_ok), 64'b10);
    tick();
    clear_bus();
    m_req = '0;
    sample();
    check("rd_c3_mem_req", 64'(mem_req), 64'd0);
    check("rd_c3_data_ok", 64'(m_data_ok), 64'd0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    sample();
    check("rd_c4_data_ok", 64'(m_data_ok), 64'b10);
    check("rd_c4_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    tick();
    clear_bus();
    sample();
    check("rd_c5_state", 64'(dut.state), 64'd0);

    // d-cache write with addr_ok and data_ok together
    m_req = 2'b10; m_wr = 2'b10; m_size = 4'b1000;
    m_addr = 64'h0000_2004_0000_0000; m_wdata = 64'h1234_5678_0000_0000;
    tick();
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    sample();
    check("wr_mem_wr", 64'(mem_wr), 64'd1);
    check("wr_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
    check("wr_mem_addr", 64'(mem_addr), 64'h2004);
    check("wr_mem_size", 64'(mem_size), 64'd2);
    check("wr_addr_ok", 64'(m_addr_ok), 64'b10);
    check("wr_data_ok", 64'(m_data_ok), 64'b10);
    m_req = '0;
    tick();
    clear_bus();
    m_wr = '0; m_wdata = '0;
    sample();
    check("wr_state_idle", 64'(dut.state), 64'd0);
    check("wr_idle_mem_req", 64'(mem_req), 64'd0);

    // Both masters request continuously for four single-cycle transactions
    begin
      logic [31:0] exp_addr [4];
`ifdef ARB_ROUND_ROBIN_EN
      exp_addr = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};
`else
      exp_addr = '{32'hB0, 32'hB0, 32'hB0, 32'hB0};
`endif
      m_req = 2'b11; m_size = 4'b1010; m_addr = 64'h0000_00B0_0000_00A0;
      for (int i = 0; i < 4; i++) begin
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        sample();
        check($sformatf("both_%0d_addr", i), 64'(mem_addr), 64'(exp_addr[i]));
        check($sformatf("both_%0d_data_ok", i), 64'(m_data_ok),
              (exp_addr[i] == 32'hA0) ? 64'b01 : 64'b10);
        tick();
        clear_bus();
        sample();
        check($sformatf("both_%0d_turn", i), 64'(mem_req), 64'd0);
      end
      m_req = '0;
      tick();
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority: d-cache first, i-cache mem_req 1 cycle after d data_ok
    m_req = 2'b11; m_addr = 64'h0000_00B0_0000_00A0;
    tick();
    mem_addr_ok = 1'b1;
    sample();
    check("fx_d_addr", 64'(mem_addr), 64'hB0);
    check("fx_d_addr_ok", 64'(m_addr_ok), 64'b10);
    tick();
    clear_bus();
    m_req = 2'b01;
    mem_data_ok = 1'b1;
    sample();
    check("fx_d_data_ok", 64'(m_data_ok), 64'b10);
    check("fx_data_mem_req", 64'(mem_req), 64'd0);
    tick();
    clear_bus();
    sample();
    check("fx_gap_mem_req", 64'(mem_req), 64'd0);
    tick();
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    sample();
    check("fx_i_mem_req", 64'(mem_req), 64'd1);
    check("fx_i_addr", 64'(mem_addr), 64'hA0);
    check("fx_i_addr_ok", 64'(m_addr_ok), 64'b01);
    check("fx_i_data_ok", 64'(m_data_ok), 64'b01);
    m_req = '0;
    tick();
    clear_bus();
`endif

    // Stray data_ok while idle is dropped
    mem_data_ok = 1'b1;
    sample();
    check("idle_stray", 64'(m_data_ok), 64'd0);
    tick();
    clear_bus();

    // Owner drops m_req in ADDR: transaction still completes
    m_req = 2'b10; m_addr = 64'h0000_3000_0000_0000;
    tick();
    m_req = '0;
    sample();
    check("drop_mem_req", 64'(mem_req), 64'd1);
    check("drop_mem_addr", 64'(mem_addr), 64'h3000);
    tick();
    mem_addr_ok = 1'b1;
    sample();
    check("drop_addr_ok", 64'(m_addr_ok), 64'b10);
    tick();
    clear_bus();
    mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0001;
    sample();
    check("drop_data_ok", 64'(m_data_ok), 64'b10);
    check("drop_rdata", 64'(m_rdata), 64'hCAFE_0001);
    tick();
    clear_bus();

    // Reset in DATA, then a stray data_ok after reset
    m_req = 2'b10; m_addr = 64'h0000_4000_0000_0000;
    tick();
    mem_addr_ok = 1'b1;
    m_req = '0;
    tick();
    clear_bus();
    rst = 1'b1;
    sample();
    check("rstd_mem_req", 64'(mem_req), 64'd0);
    check("rstd_data_ok", 64'(m_data_ok), 64'd0);
    tick();
    rst = 1'b0;
    mem_data_ok = 1'b1;
    sample();
    check("rstd_stray", 64'(m_data_ok), 64'd0);
    check("rstd_state", 64'(dut.state), 64'd0);
    tick();
    clear_bus();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of every address field; the only legal value is 32.
REQ-002 clk  input  1  single clock; all state updates on the posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 m_req  input  2  per-master request; bit0 = i-cache, bit1 = d-cache (same indexing for all m_* ports).
REQ-005 m_wr  input  2  per-master write flag (1 = write).
REQ-006 m_size  input  4  per-master size; [1:0] = master 0, [3:2] = master 1.
REQ-007 m_addr  input  64  per-master address; [31:0] = master 0, [63:32] = master 1.
REQ-008 m_wdata  input  64  per-master write data, packed as m_addr.
REQ-009 m_rdata  output  32  read data, broadcast to both masters.
REQ-010 m_addr_ok  output  2  per-master address accepted.
REQ-011 m_data_ok  output  2  per-master transfer complete.
REQ-012 mem_req, mem_wr  output  1 each  request and write flag to the shared sram-like port.
REQ-013 mem_size  output  2  size to the shared port.
REQ-014 mem_addr, mem_wdata  output  32 each  address and write data to the shared port.
REQ-015 mem_rdata  input  32  read data from the shared port.
REQ-016 mem_addr_ok, mem_data_ok  input  1 each  shared-port handshakes.

Function
REQ-017 The FSM SHALL have three states, IDLE, ADDR and DATA, and SHALL allow at most one outstanding transaction.
REQ-018 IDLE: any m_req bit set -> register the owner chosen by the priority rule (REQ-024) and go to ADDR; mem_req = 0 in IDLE (1-cycle arbitration latency).
REQ-019 ADDR: mem_req = 1; mem_wr, mem_size, mem_addr and mem_wdata are the owner's fields; m_addr_ok[owner] = mem_addr_ok; mem_addr_ok -> DATA.
REQ-020 ADDR with mem_addr_ok and mem_data_ok in the same cycle: forward both handshakes to the owner and go directly to IDLE.
REQ-021 DATA: mem_req = 0; m_data_ok[owner] = mem_data_ok; mem_data_ok -> IDLE.
REQ-022 m_rdata SHALL equal mem_rdata in every state; the non-owner's m_addr_ok and m_data_ok bits SHALL always be 0.
REQ-023 The owner SHALL hold its request fields stable until m_addr_ok; if the owner drops m_req in ADDR, the arbiter still completes the transaction and responds.
REQ-024 Default priority is fixed: d-cache (bit1) wins when both masters request in IDLE.
REQ-025 A mem_data_ok arriving in IDLE SHALL be dropped, not forwarded.
REQ-026 Back-to-back: a request that is pending when DATA returns to IDLE is granted in that IDLE cycle; the minimum turnaround between transactions is 1 cycle.

Reset
REQ-027 rst SHALL force state = IDLE, owner = 0 and last_grant = 1; all outputs are 0 during reset and in IDLE with no request; an in-flight transaction is abandoned.

Configuration
REQ-028 With ARB_ROUND_ROBIN_EN defined, on a tie the master not in last_grant wins, and last_grant updates on every grant.
REQ-029 With ARB_ROUND_ROBIN_EN undefined, the fixed priority of REQ-024 applies and last_grant is not implemented.

Structure
REQ-030 A shared package cache_bus_pkg SHALL hold the state encodings (IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b11) and the master indices (M_INST = 0, M_DATA = 1).
REQ-031 The block SHALL contain one sub-module, arb2_pick: combinational 2-way grant selection from m_req and last_grant.

Verification
REQ-032 Single d-cache read of addr 0x1000; mem_addr_ok at cycle 2, mem_data_ok with rdata 0xDEADBEEF at cycle 4 -> m_addr_ok = 2'b10 at cycle 2; m_data_ok = 2'b10 and m_rdata = 0xDEADBEEF at cycle 4.
REQ-033 Both masters request in the same cycle, fixed mode -> d-cache transaction issued first; i-cache mem_req rises 1 cycle after the d-cache data_ok.
REQ-034 Both masters request continuously with ARB_ROUND_ROBIN_EN, 4 transactions -> grant order i, d, i, d.
REQ-035 d-cache write of addr 0x2004, data 0x12345678, size 2'b10, with addr_ok and data_ok in the same cycle -> state returns to IDLE the next cycle; mem_wdata = 0x12345678 and mem_wr = 1 while in ADDR.
REQ-036 rst asserted while in DATA, then a stray mem_data_ok after reset -> m_data_ok stays 2'b00 and the FSM is in IDLE.
